intersections_seq: RTL and testbench

- Sequential, handshaked circle–circle intersection engine for the trilateration datapath.
- Inputs: two circles, K = (xK, yK, rK) and L = (xL, yL, rL).
- Outputs: both intersection points plus status flags.
- Successor to the combinational intersections block: parametrised width, valid/ready flow control, degenerate-case flags, and an iterative shared sqrt/divider instead of a flat combinational datapath.

---
 rtl/intersections_seq.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_intersections_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/intersections_seq.sv
// Sequential circle-circle intersection engine for the trilateration datapath.
// Latency: accept at t -> out_valid at t+5N+8 (normal) or t+2 (coincident / disjoint).
// Backpressure: single-entry, in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready=1 only while idle
//   g_input               circle K {xK[N-1:0], yK[N-1:0], rK[N:0]}, xK at MSBs
//   e_input               circle L {xL, yL, rL}, same packing
//   out_valid / out_ready output handshake
//   o                     {x1P, y1P, x2P, y2P}, each signed N+2 bits, x1P at MSBs
//   status                {coincident, no_intersect, tangent}, meaningful while out_valid
//
// Datapath: one cycle to form D, A, S; a non-restoring bit-serial square root of S
// (2 bits per cycle); four restoring dividers sharing divisor Q=2D (1 bit per cycle);
// one cycle to add the base coordinates and register the result.

module intersections_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*N:0]   g_input,
    input  logic [3*N:0]   e_input,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*N+7:0] o,
    output logic [2:0]     status
);

    localparam int DW       = 2*N + 1;   // D = dx^2 + dy^2
    localparam int AW       = 2*N + 3;   // A = rK^2 - rL^2 + D
    localparam int SW       = 4*N + 6;   // S = 4*D*rK^2 - A^2
    localparam int RW       = 2*N + 2;   // R = floor(sqrt(S))
    localparam int SQW      = 2*RW;      // S is below 2^SQW whenever it is non-negative
    localparam int REMW     = RW + 5;    // signed sqrt partial remainder
    localparam int NW       = 3*N + 5;   // signed numerators
    localparam int MW       = 3*N + 4;   // numerator magnitudes / quotients
    localparam int QW       = 2*N + 2;   // divisor Q = 2D
    localparam int PW       = N + 2;     // output coordinate width
    localparam int SQRT_CYC = 2*N + 2;
    localparam int DIV_CYC  = 3*N + 4;
    localparam int CW       = $clog2(DIV_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SQRT,
        S_DIV,
        S_FIN,
        S_DONE
    } state_t;

    state_t state_q;

    // Latched circles
    logic signed [N-1:0] xk_q, yk_q, xl_q, yl_q;
    logic        [N:0]   rk_q, rl_q;

    // Values carried from CALC into the iterative stages
    logic signed [N:0]    dx_q, dy_q;
    logic signed [AW-1:0] a_q;
    logic        [QW-1:0] qdiv_q;
    logic        [2:0]    flags_q;
    logic                 degen_q;
    logic        [CW-1:0] cnt_q;

    // Square root state
    logic        [SQW-1:0]  s_q;     // operand, consumed two bits at a time from the top
    logic signed [REMW-1:0] rem_q;
    logic        [RW-1:0]   root_q;

    // Divider state: dvd_q shifts the dividend out and the quotient in
    logic [MW-1:0] dvd_q  [4];
    logic [QW-1:0] drem_q [4];
    logic [3:0]    neg_q;

    // ------------------------------------------------------------------
    // CALC: D, A, S from the latched circles
    // ------------------------------------------------------------------
    logic signed [N:0]    dx_d, dy_d;
    logic signed [DW-1:0] dx_e, dy_e;
    logic        [DW-1:0] d_d;
    logic        [2*N+1:0] rk_e, rl_e, rk_sq, rl_sq;
    logic signed [AW-1:0] a_d;
    logic signed [SW-1:0] a_e, a_sq, s_d;
    logic        [SW-1:0] t1;

    always_comb begin
        dx_d  = {xl_q[N-1], xl_q} - {xk_q[N-1], xk_q};
        dy_d  = {yl_q[N-1], yl_q} - {yk_q[N-1], yk_q};
        dx_e  = {{N{dx_d[N]}}, dx_d};
        dy_e  = {{N{dy_d[N]}}, dy_d};
        d_d   = $unsigned(dx_e * dx_e) + $unsigned(dy_e * dy_e);
        rk_e  = {{(N+1){1'b0}}, rk_q};
        rl_e  = {{(N+1){1'b0}}, rl_q};
        rk_sq = rk_e * rk_e;
        rl_sq = rl_e * rl_e;
        a_d   = $signed({1'b0, rk_sq}) - $signed({1'b0, rl_sq}) + $signed({2'b00, d_d});
        a_e   = {{(SW-AW){a_d[AW-1]}}, a_d};
        a_sq  = a_e * a_e;
        // 4*D folded into the multiplicand as a 2-bit left shift
        t1    = {{(SW-DW-2){1'b0}}, d_d, 2'b00} * {{(SW-2*N-2){1'b0}}, rk_sq};
        s_d   = $signed(t1) - a_sq;
    end

    // ------------------------------------------------------------------
    // SQRT step (non-restoring): the remainder is allowed to go negative
    // and is corrected on the next step instead of being restored.
    // ------------------------------------------------------------------
    logic        [1:0]    pair;
    logic signed [REMW:0] rem_sh, rem_n;
    logic        [RW-1:0] root_n;

    always_comb begin
        pair   = s_q[SQW-1 -: 2];
        rem_sh = {rem_q[REMW-2:0], pair};
        if (rem_q[REMW-1]) begin
            rem_n = rem_sh + $signed({4'b0000, root_q, 2'b11});
        end else begin
            rem_n = rem_sh - $signed({4'b0000, root_q, 2'b01});
        end
        root_n = {root_q[RW-2:0], ~rem_n[REMW]};
    end

    // ------------------------------------------------------------------
    // Numerators, formed from the final root on the last SQRT cycle.
    // Lanes: 0=x1, 1=y1, 2=x2, 3=y2.
    // ------------------------------------------------------------------
    logic signed [NW-1:0] a_n, dx_n, dy_n, r_n;
    logic signed [NW-1:0] adx, ady, dxr, dyr;
    logic signed [NW-1:0] num   [4];
    logic        [MW-1:0] mag   [4];
    logic        [3:0]    neg_d;

    always_comb begin
        a_n    = {{(NW-AW){a_q[AW-1]}}, a_q};
        dx_n   = {{(NW-N-1){dx_q[N]}}, dx_q};
        dy_n   = {{(NW-N-1){dy_q[N]}}, dy_q};
        r_n    = {{(NW-RW){1'b0}}, root_n};
        adx    = a_n * dx_n;
        ady    = a_n * dy_n;
        dxr    = dx_n * r_n;
        dyr    = dy_n * r_n;
        num[0] = adx - dyr;
        num[1] = ady + dxr;
        num[2] = adx + dyr;
        num[3] = ady - dxr;
        // Divide magnitudes, re-apply the sign afterwards: truncation toward zero
        for (int i = 0; i < 4; i++) begin
            neg_d[i] = num[i][NW-1];
            mag[i]   = neg_d[i] ? (~num[i][MW-1:0] + MW'(1)) : num[i][MW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Restoring divider step; the borrow of the trial subtraction is the
    // quotient bit, so no separate comparator is needed.
    // ------------------------------------------------------------------
    logic [QW:0] rem_t [4];
    logic [QW:0] diff  [4];
    logic [3:0]  ge;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rem_t[i] = {drem_q[i], dvd_q[i][MW-1]};
            diff[i]  = rem_t[i] - {1'b0, qdiv_q};
            ge[i]    = ~diff[i][QW];
        end
    end

    // ------------------------------------------------------------------
    // FIN: signed quotient plus base coordinate
    // ------------------------------------------------------------------
    logic signed [PW-1:0] base [4];
    logic signed [PW-1:0] qs   [4];
    logic signed [PW-1:0] pt   [4];
    logic        [4*N+7:0] o_d;

    always_comb begin
        base[0] = {{2{xk_q[N-1]}}, xk_q};
        base[1] = {{2{yk_q[N-1]}}, yk_q};
        base[2] = {{2{xk_q[N-1]}}, xk_q};
        base[3] = {{2{yk_q[N-1]}}, yk_q};
        for (int i = 0; i < 4; i++) begin
            qs[i] = neg_q[i] ? -$signed(dvd_q[i][PW-1:0]) : $signed(dvd_q[i][PW-1:0]);
            pt[i] = base[i] + qs[i];
        end
        o_d = degen_q ? '0 : {pt[0], pt[1], pt[2], pt[3]};
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            o         <= '0;
            status    <= '0;
            xk_q      <= '0;
            yk_q      <= '0;
            xl_q      <= '0;
            yl_q      <= '0;
            rk_q      <= '0;
            rl_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            a_q       <= '0;
            qdiv_q    <= '0;
            flags_q   <= '0;
            degen_q   <= 1'b0;
            cnt_q     <= '0;
            s_q       <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            neg_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                dvd_q[i]  <= '0;
                drem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        xk_q     <= g_input[3*N:2*N+1];
                        yk_q     <= g_input[2*N:N+1];
                        rk_q     <= g_input[N:0];
                        xl_q     <= e_input[3*N:2*N+1];
                        yl_q     <= e_input[2*N:N+1];
                        rl_q     <= e_input[N:0];
                        in_ready <= 1'b0;
                        state_q  <= S_CALC;
                    end
                end

                S_CALC: begin
                    dx_q   <= dx_d;
                    dy_q   <= dy_d;
                    a_q    <= a_d;
                    qdiv_q <= {d_d, 1'b0};
                    s_q    <= s_d[SQW-1:0];
                    rem_q  <= '0;
                    root_q <= '0;
                    cnt_q  <= '0;
                    // Degenerate cases skip the iterative stages but still
                    // pass through FIN so o/status update in one place.
                    if (d_d == '0) begin
                        flags_q <= 3'b100;
                        degen_q <= 1'b1;
                        state_q <= S_FIN;
                    end else if (s_d[SW-1] || rk_q[N] || rl_q[N]) begin
                        flags_q <= 3'b010;
                        degen_q <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        flags_q <= {2'b00, (s_d == '0)};
                        degen_q <= 1'b0;
                        state_q <= S_SQRT;
                    end
                end

                S_SQRT: begin
                    s_q    <= {s_q[SQW-3:0], 2'b00};
                    rem_q  <= rem_n[REMW-1:0];
                    root_q <= root_n;
                    if (cnt_q == CW'(SQRT_CYC - 1)) begin
                        cnt_q   <= '0;
                        neg_q   <= neg_d;
                        for (int i = 0; i < 4; i++) begin
                            dvd_q[i]  <= mag[i];
                            drem_q[i] <= '0;
                        end
                        state_q <= S_DIV;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DIV: begin
                    for (int i = 0; i < 4; i++) begin
                        dvd_q[i]  <= {dvd_q[i][MW-2:0], ge[i]};
                        drem_q[i] <= ge[i] ? diff[i][QW-1:0] : rem_t[i][QW-1:0];
                    end
                    if (cnt_q == CW'(DIV_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_FIN: begin
                    o         <= o_d;
                    status    <= flags_q;
                    out_valid <= 1'b1;
                    state_q   <= S_DONE;
                end

                S_DONE: begin
                    // The release cycle itself never accepts; in_ready rises after it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intersections_seq.sv
// Directed bench for intersections_seq (N=8): reset, intersecting, disjoint,
// concentric, tangent and vertical-offset circles, output hold and mid-run reset.

module tb_intersections_seq;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3*N:0]   g_input;
    logic [3*N:0]   e_input;
    logic           out_valid;
    logic           out_ready;
    logic [4*N+7:0] o;
    logic [2:0]     status;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    intersections_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_input   (g_input),
        .e_input   (e_input),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .status    (status)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3*N:0] circ(input int x, input int y, input int r);
        return {N'(x), N'(y), (N+1)'(r)};
    endfunction

    function automatic logic [4*N+7:0] pts(input int x1, input int y1, input int x2, input int y2);
        return {(N+2)'(x1), (N+2)'(y1), (N+2)'(x2), (N+2)'(y2)};
    endfunction

    // Present one request, wait for the result, check latency, o and status.
    // Leaves the engine in DONE with the result held.
    task automatic run_case(input string tag, input logic [3*N:0] g, input logic [3*N:0] e,
                            input logic [4*N+7:0] exp_o, input logic [2:0] exp_st,
                            input int exp_lat);
        int lat;
        @(negedge clk);
        check_eq({tag, " idle_rdy"}, 64'(in_ready), 64'd1);
        g_input  = g;
        e_input  = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq({tag, " busy_rdy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " o"}, 64'(o), 64'(exp_o));
        check_eq({tag, " status"}, 64'(status), 64'(exp_st));
        check_eq({tag, " done_rdy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " rel_vld"}, 64'(out_valid), 64'd0);
        check_eq({tag, " rel_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hits;

        // Reset held 3 cycles with a valid request pending: nothing accepted
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        g_input   = circ(-16, -111, 236);
        e_input   = circ(109, -99, 183);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("reset_state", 64'({in_ready, out_valid, status, o}),
                     64'({1'b1, 1'b0, 3'b000, 40'd0}));
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_after_reset", 64'({in_ready, out_valid}), 64'b10);

        // Intersecting circles, then hold the result with out_ready low
        run_case("intersect", circ(-16, -111, 236), circ(109, -99, 183),
                 pts(117, 83, 151, -276), 3'b000, 48);
        g_input  = circ(0, 0, 5);
        e_input  = circ(10, 0, 5);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold", 64'({out_valid, in_ready, status, o}),
                     64'({1'b1, 1'b0, 3'b000, pts(117, 83, 151, -276)}));
        end
        in_valid = 1'b0;
        consume("intersect");

        run_case("disjoint", circ(0, 0, 10), circ(100, 0, 10), 40'd0, 3'b010, 2);
        consume("disjoint");

        run_case("concentric", circ(5, 5, 20), circ(5, 5, 30), 40'd0, 3'b100, 2);
        consume("concentric");

        run_case("tangent", circ(0, 0, 5), circ(10, 0, 5), pts(5, 0, 5, 0), 3'b001, 48);
        consume("tangent");

        // dx=0, dy=6: S=2304, R=48, Q=72 -> (-4,3) and (4,3)
        run_case("vertical", circ(0, 0, 5), circ(0, 6, 5), pts(-4, 3, 4, 3), 3'b000, 48);
        consume("vertical");

        // Reset in the middle of the square-root stage
        @(negedge clk);
        g_input  = circ(-16, -111, 236);
        e_input  = circ(109, -99, 183);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrun_reset", 64'({in_ready, out_valid, status, o}),
                 64'({1'b1, 1'b0, 3'b000, 40'd0}));
        @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) hits++;
        end
        check_eq("aborted_quiet", 64'(hits), 64'd0);

        // Engine usable again after the abort
        run_case("after_rst", circ(0, 0, 5), circ(10, 0, 5), pts(5, 0, 5, 0), 3'b001, 48);
        consume("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
